// File: rtl/weight_bias_load_scheduler.sv
// Per-group weight/bias load sequencer: a fetch engine streams group words from
// memory into the weight FIFO while a load engine hands complete groups to the PEs.
module weight_bias_load_scheduler #(
    parameter int ADDR_WIDTH      = 32,
    parameter int MEM_DATA_WIDTH  = 512,
    parameter int BURST_LEN       = 64,
    parameter int MAX_GROUP_WORDS = 256
) (
    input  logic                  system_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [15:0]           cfg_group_num,
    input  logic [8:0]            cfg_group_words,
    input  logic                  cfg_bias_en,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_req,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic [7:0]            mem_rd_len,
    input  logic                  mem_rd_ack,
    input  logic                  weight_and_bias_valid,
    input  logic                  weight_buffer_ready,
    input  logic                  weight_and_bias_ready,
    output logic [1:0]            change_weight_bias,
    output logic                  weights_loaded,
    input  logic                  compute_group_done
);

    localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(MEM_DATA_WIDTH / 8);

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_DATA} fetch_state_t;
    typedef enum logic [2:0] {L_IDLE, L_WAIT_DATA, L_ISSUE, L_LOADING, L_INUSE, L_DONE} load_state_t;

    fetch_state_t          f_state_reg, f_state_next;
    load_state_t           l_state_reg, l_state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [7:0]            len_reg;
    logic [7:0]            beat_cnt_reg;
    logic [24:0]           remaining_reg;
    logic [24:0]           fetched_words_reg;
    logic [24:0]           loaded_words_reg;
    logic [15:0]           group_num_reg;
    logic [8:0]            group_words_reg;
    logic                  bias_en_reg;
    logic [15:0]           group_idx_reg;
    logic                  group_done_flag_reg;
    logic                  seen_low_reg;
    logic [1:0]            cwb_reg;
    logic                  weights_loaded_reg;

    logic                  start_accept;
    logic [8:0]            group_words_clamped;
    logic [24:0]           total_words;
    logic [7:0]            burst_len_next;
    logic                  beat;
    logic                  burst_last;
    logic                  group_ready;
    logic                  group_consume;
    logic                  load_complete;

    assign start_accept        = start && (l_state_reg == L_IDLE);
    // Oversized groups are clamped so a group can never exceed the FIFO.
    assign group_words_clamped = (cfg_group_words > 9'(MAX_GROUP_WORDS)) ? 9'(MAX_GROUP_WORDS) : cfg_group_words;
    assign total_words         = 25'(cfg_group_num) * 25'(group_words_clamped);
    assign burst_len_next      = (remaining_reg >= 25'(BURST_LEN)) ? 8'(BURST_LEN) : remaining_reg[7:0];
    assign beat                = (f_state_reg == F_DATA) && weight_and_bias_valid;
    assign burst_last          = beat && ((beat_cnt_reg + 8'd1) == len_reg);
    assign group_ready         = (fetched_words_reg - loaded_words_reg) >= 25'(group_words_reg);
    assign group_consume       = (l_state_reg == L_INUSE) && (group_done_flag_reg || compute_group_done);
    assign load_complete       = (l_state_reg == L_LOADING) && seen_low_reg && weight_and_bias_ready;

    always_comb begin
        f_state_next = f_state_reg;
        case (f_state_reg)
            F_IDLE:  if (remaining_reg != '0 && weight_buffer_ready) f_state_next = F_REQ;
            F_REQ:   if (mem_rd_ack) f_state_next = F_DATA;
            F_DATA:  if (burst_last) f_state_next = F_IDLE;
            default: f_state_next = F_IDLE;
        endcase
    end

    always_comb begin
        l_state_next = l_state_reg;
        case (l_state_reg)
            L_IDLE:      if (start_accept) l_state_next = L_WAIT_DATA;
            L_WAIT_DATA: begin
                if (group_num_reg == '0)  l_state_next = L_DONE;
                else if (group_ready)     l_state_next = L_ISSUE;
            end
            L_ISSUE:     if (weight_and_bias_ready) l_state_next = L_LOADING;
            L_LOADING:   if (load_complete) l_state_next = L_INUSE;
            L_INUSE: begin
                if (group_consume)
                    l_state_next = (group_idx_reg == group_num_reg) ? L_DONE : L_WAIT_DATA;
            end
            L_DONE:      l_state_next = L_IDLE;
            default:     l_state_next = L_IDLE;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (rst) begin
            f_state_reg         <= F_IDLE;
            l_state_reg         <= L_IDLE;
            addr_reg            <= '0;
            len_reg             <= '0;
            beat_cnt_reg        <= '0;
            remaining_reg       <= '0;
            fetched_words_reg   <= '0;
            loaded_words_reg    <= '0;
            group_num_reg       <= '0;
            group_words_reg     <= '0;
            bias_en_reg         <= 1'b0;
            group_idx_reg       <= '0;
            group_done_flag_reg <= 1'b0;
            seen_low_reg        <= 1'b0;
            cwb_reg             <= 2'b00;
            weights_loaded_reg  <= 1'b0;
        end else begin
            f_state_reg <= f_state_next;
            l_state_reg <= l_state_next;

            if (start_accept) begin
                group_num_reg     <= cfg_group_num;
                group_words_reg   <= group_words_clamped;
                bias_en_reg       <= cfg_bias_en;
                addr_reg          <= cfg_base_addr;
                remaining_reg     <= total_words;
                fetched_words_reg <= '0;
                loaded_words_reg  <= '0;
                group_idx_reg     <= '0;
            end else begin
                if (f_state_reg == F_IDLE && f_state_next == F_REQ)
                    len_reg <= burst_len_next;
                if (beat) begin
                    beat_cnt_reg      <= burst_last ? 8'd0 : beat_cnt_reg + 8'd1;
                    fetched_words_reg <= fetched_words_reg + 25'd1;
                end
                if (burst_last) begin
                    addr_reg      <= addr_reg + ADDR_WIDTH'(len_reg) * WORD_BYTES;
                    remaining_reg <= remaining_reg - 25'(len_reg);
                end
                if (load_complete) begin
                    group_idx_reg    <= group_idx_reg + 16'd1;
                    loaded_words_reg <= loaded_words_reg + 25'(group_words_reg);
                end
            end

            // Completion pulses are remembered until the load engine can use them.
            if (start_accept)
                group_done_flag_reg <= 1'b0;
            else
                group_done_flag_reg <= (group_done_flag_reg || compute_group_done) && !group_consume;

            if (l_state_reg == L_ISSUE)
                seen_low_reg <= 1'b0;
            else if (l_state_reg == L_LOADING && !weight_and_bias_ready)
                seen_low_reg <= 1'b1;

            cwb_reg            <= (l_state_reg == L_ISSUE && weight_and_bias_ready) ? {bias_en_reg, 1'b1} : 2'b00;
            weights_loaded_reg <= load_complete;
        end
    end

    assign busy               = (l_state_reg != L_IDLE);
    assign done               = (l_state_reg == L_DONE);
    assign mem_rd_req         = (f_state_reg == F_REQ);
    assign mem_rd_addr        = addr_reg;
    assign mem_rd_len         = len_reg;
    assign change_weight_bias = cwb_reg;
    assign weights_loaded     = weights_loaded_reg;

endmodule

// File: tb/tb_weight_bias_load_scheduler.sv
// Randomised scoreboard bench: memory, weight buffer and compute side are modelled
// behaviourally; expected bursts, commands and done are queued at each start.
module tb_weight_bias_load_scheduler;

    localparam int BURST = 64;
    localparam int DEPTH = 512;
    localparam int WORD_B = 64;

    logic        system_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] cfg_base_addr = '0;
    logic [15:0] cfg_group_num = '0;
    logic [8:0]  cfg_group_words = '0;
    logic        cfg_bias_en = 1'b0;
    logic        busy, done, mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic [7:0]  mem_rd_len;
    logic        mem_rd_ack, weight_and_bias_valid, weight_buffer_ready, weight_and_bias_ready;
    logic [1:0]  change_weight_bias;
    logic        weights_loaded, compute_group_done;

    weight_bias_load_scheduler dut (
        .system_clk(system_clk), .rst(rst), .start(start),
        .cfg_base_addr(cfg_base_addr), .cfg_group_num(cfg_group_num),
        .cfg_group_words(cfg_group_words), .cfg_bias_en(cfg_bias_en),
        .busy(busy), .done(done), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
        .mem_rd_len(mem_rd_len), .mem_rd_ack(mem_rd_ack),
        .weight_and_bias_valid(weight_and_bias_valid), .weight_buffer_ready(weight_buffer_ready),
        .weight_and_bias_ready(weight_and_bias_ready), .change_weight_bias(change_weight_bias),
        .weights_loaded(weights_loaded), .compute_group_done(compute_group_done)
    );

    always #5 system_clk = ~system_clk;

    int cyc = 0;
    always @(posedge system_clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard queues and shared configuration
    logic [31:0] exp_addr_q[$];
    int          exp_len_q[$];
    int          exp_cmd_q[$];
    int          exp_done_q[$];
    int          cur_gw = 0;
    bit          cur_zero = 0;
    bit          early_mode = 0;
    int          start_cyc = 0;
    int          stall_at_burst = -1;
    logic        tb_flush = 1'b0;

    // Memory model
    int          m_state = 0, m_delay = 0, m_left = 0, m_len = 0, burst_cnt = 0;
    logic [31:0] m_addr = '0;
    logic        force_low = 1'b0;
    int          stall_left = 0, stall_rel_cyc = 0;

    initial begin
        mem_rd_ack = 1'b0;
        weight_and_bias_valid = 1'b0;
        forever begin
            @(posedge system_clk); #1;
            mem_rd_ack = 1'b0;
            weight_and_bias_valid = 1'b0;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) begin
                    force_low = 1'b0;
                    stall_rel_cyc = cyc;
                end
            end
            if (m_state == 0 && mem_rd_req) begin
                m_addr = mem_rd_addr;
                m_len = int'(mem_rd_len);
                m_delay = $urandom_range(0, 3);
                m_state = 1;
            end
            if (m_state == 1) begin
                if (!mem_rd_req) m_state = 0;
                else begin
                    check("req_hold_addr", mem_rd_addr, m_addr);
                    check("req_hold_len", mem_rd_len, m_len);
                    if (m_delay == 0) begin
                        mem_rd_ack = 1'b1;
                        m_left = m_len;
                        m_state = 2;
                    end else m_delay--;
                end
            end else if (m_state == 2) begin
                if ($urandom_range(0, 3) != 0) begin
                    weight_and_bias_valid = 1'b1;
                    m_left--;
                    if (m_left <= 0) begin
                        m_state = 0;
                        burst_cnt++;
                        if (burst_cnt == stall_at_burst) begin
                            force_low = 1'b1;
                            stall_left = 50;
                        end
                    end
                end
            end
        end
    end

    // Weight FIFO occupancy and weight-buffer handshake model
    int words_in = 0;
    int words_out = 0;
    int b_state = 0, b_hold = 0, b_low = 0, b_gw = 0, rdy_rise_cyc = 0;

    always @(posedge system_clk) begin
        if (tb_flush) words_in <= 0;
        else if (weight_and_bias_valid) words_in <= words_in + 1;
    end

    assign weight_buffer_ready = !force_low && ((words_in - words_out + BURST) <= DEPTH);

    initial begin
        weight_and_bias_ready = 1'b1;
        forever begin
            @(posedge system_clk); #1;
            if (tb_flush) begin
                words_out = 0;
                b_state = 0;
                weight_and_bias_ready = 1'b1;
            end else if (b_state == 0) begin
                if (change_weight_bias != 2'b00) begin
                    b_gw = cur_gw;
                    b_hold = $urandom_range(0, 2);
                    b_low = $urandom_range(2, 10);
                    b_state = 1;
                end
            end else if (b_state == 1) begin
                if (b_hold == 0) begin
                    weight_and_bias_ready = 1'b0;
                    b_state = 2;
                end else b_hold--;
            end else begin
                if (b_low == 0) begin
                    weight_and_bias_ready = 1'b1;
                    words_out = words_out + b_gw;
                    rdy_rise_cyc = cyc;
                    b_state = 0;
                end else b_low--;
            end
        end
    end

    // Compute side: finishes a group some cycles after it is loaded, or (early mode)
    // reports completion while the next group is still being loaded.
    int c_cnt = 0, last_cgd_cyc = 0;
    initial begin
        compute_group_done = 1'b0;
        forever begin
            @(posedge system_clk); #1;
            compute_group_done = 1'b0;
            if (c_cnt > 0) begin
                c_cnt--;
                if (c_cnt == 0) begin
                    compute_group_done = 1'b1;
                    last_cgd_cyc = cyc;
                end
            end
            if (!early_mode && weights_loaded) c_cnt = $urandom_range(1, 15);
            if (early_mode && change_weight_bias != 2'b00) c_cnt = 1;
        end
    end

    // Monitor
    int   wl_cnt = 0, done_cnt = 0, last_wl_cyc = 0, rel_seen = 0, max_occ = 0;
    logic prev_req = 0, prev_wbr = 0, prev_wabr = 0, prev_done = 0;
    logic [1:0] prev_cwb = 0;

    initial begin
        forever begin
            int occ;
            @(negedge system_clk);
            occ = words_in - words_out;
            if (occ > max_occ) max_occ = occ;
            if (mem_rd_req && !prev_req) begin
                check("req_only_when_ready", prev_wbr, 1);
                if (stall_rel_cyc != rel_seen) begin
                    check("resume_after_stall", cyc, stall_rel_cyc + 1);
                    rel_seen = stall_rel_cyc;
                end
            end
            if (mem_rd_req && mem_rd_ack) begin
                if (exp_addr_q.size() == 0) check("unexpected_burst", 1, 0);
                else begin
                    logic [31:0] ea;
                    int el;
                    ea = exp_addr_q.pop_front();
                    el = exp_len_q.pop_front();
                    check("burst_addr", mem_rd_addr, ea);
                    check("burst_len", mem_rd_len, el);
                    $display("burst addr=%h len=%0d cycle=%0d", mem_rd_addr, mem_rd_len, cyc);
                end
            end
            if (change_weight_bias != 2'b00) begin
                if (exp_cmd_q.size() == 0) check("unexpected_command", 1, 0);
                else check("command_value", change_weight_bias, exp_cmd_q.pop_front());
                check("command_when_idle", prev_wabr, 1);
                check("command_group_resident", occ >= cur_gw, 1);
                $display("command %b occupancy=%0d cycle=%0d", change_weight_bias, occ, cyc);
            end
            if (prev_cwb != 2'b00) check("command_one_cycle", change_weight_bias, 0);
            if (weights_loaded) begin
                check("loaded_after_ready", cyc, rdy_rise_cyc + 1);
                wl_cnt++;
                last_wl_cyc = cyc;
                $display("weights_loaded cycle=%0d", cyc);
            end
            if (prev_done) check("done_one_cycle", done, 0);
            if (done) begin
                if (exp_done_q.size() == 0) check("unexpected_done", 1, 0);
                else begin
                    void'(exp_done_q.pop_front());
                    if (cur_zero) check("done_latency_zero", cyc, start_cyc + 2);
                    else check("done_latency", cyc,
                               ((last_wl_cyc > last_cgd_cyc) ? last_wl_cyc : last_cgd_cyc) + 1);
                end
                done_cnt++;
                $display("done cycle=%0d", cyc);
            end
            prev_req = mem_rd_req;
            prev_wbr = weight_buffer_ready;
            prev_wabr = weight_and_bias_ready;
            prev_done = done;
            prev_cwb = change_weight_bias;
        end
    end

    int wl_start = 0, done_start = 0;

    task automatic start_layer(input logic [31:0] base, input int gn, input int gw,
                               input bit bias, input bit early, input bit stall);
        logic [31:0] a;
        int rem, l;
        a = base;
        rem = gn * gw;
        while (rem > 0) begin
            l = (rem < BURST) ? rem : BURST;
            exp_addr_q.push_back(a);
            exp_len_q.push_back(l);
            a = a + l * WORD_B;
            rem = rem - l;
        end
        for (int g = 0; g < gn; g++) exp_cmd_q.push_back(bias ? 3 : 1);
        exp_done_q.push_back(1);
        cur_gw = gw;
        cur_zero = (gn == 0);
        early_mode = early;
        wl_start = wl_cnt;
        done_start = done_cnt;
        stall_at_burst = stall ? burst_cnt + 2 : -1;
        @(negedge system_clk);
        cfg_base_addr = base;
        cfg_group_num = 16'(gn);
        cfg_group_words = 9'(gw);
        cfg_bias_en = bias;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge system_clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
    endtask

    task automatic finish_layer(input int gn);
        int t;
        t = 0;
        while (done_cnt == done_start && t < 20000) begin
            @(negedge system_clk);
            t++;
        end
        check("layer_completed", done_cnt != done_start, 1);
        repeat (3) @(negedge system_clk);
        check("busy_after_done", busy, 0);
        check("loaded_group_count", wl_cnt - wl_start, gn);
        check("bursts_outstanding", exp_addr_q.size(), 0);
        check("commands_outstanding", exp_cmd_q.size(), 0);
        check("done_outstanding", exp_done_q.size(), 0);
        exp_addr_q.delete(); exp_len_q.delete(); exp_cmd_q.delete(); exp_done_q.delete();
    endtask

    task automatic run_layer(input logic [31:0] base, input int gn, input int gw,
                             input bit bias, input bit early, input bit stall, input bit poke);
        start_layer(base, gn, gw, bias, early, stall);
        if (poke) begin
            repeat (5) @(negedge system_clk);
            check("busy_at_extra_start", busy, 1);
            cfg_base_addr = 32'hDEAD_0000;
            cfg_group_num = 16'd7;
            start = 1'b1;
            @(negedge system_clk);
            start = 1'b0;
        end
        finish_layer(gn);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge system_clk);
        check("reset_outputs", {busy, done, mem_rd_req, mem_rd_addr, mem_rd_len,
                                change_weight_bias, weights_loaded}, 0);
        rst = 1'b0;
        @(negedge system_clk);
        check("idle_outputs", {busy, done, mem_rd_req, change_weight_bias, weights_loaded}, 0);

        run_layer(32'h0000_1000, 1, 37, 1, 0, 0, 0);
        run_layer(32'h0001_0000, 3, 100, 0, 0, 0, 1);
        run_layer(32'h0004_0000, 4, 256, 1, 0, 1, 0);
        run_layer(32'h0008_0000, 3, 50, 0, 1, 0, 0);
        run_layer(32'h0000_5000, 0, 10, 1, 0, 0, 0);

        // Abort while a group is loading, then rerun the same layer from scratch
        start_layer(32'h0010_0000, 3, 100, 1, 0, 0);
        t = 0;
        while (exp_cmd_q.size() == 3 && t < 5000) begin
            @(negedge system_clk);
            t++;
        end
        check("first_command_seen", exp_cmd_q.size(), 2);
        rst = 1'b1;
        @(negedge system_clk);
        check("abort_outputs", {busy, done, mem_rd_req, mem_rd_addr, mem_rd_len,
                                change_weight_bias, weights_loaded}, 0);
        rst = 1'b0;
        exp_addr_q.delete(); exp_len_q.delete(); exp_cmd_q.delete(); exp_done_q.delete();
        t = 0;
        while ((m_state != 0 || b_state != 0 || c_cnt != 0) && t < 2000) begin
            @(negedge system_clk);
            t++;
        end
        tb_flush = 1'b1;
        @(negedge system_clk);
        tb_flush = 1'b0;
        run_layer(32'h0010_0000, 3, 100, 1, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] rb;
            rb = $urandom;
            rb[5:0] = 6'd0;
            run_layer(rb, $urandom_range(1, 4), $urandom_range(1, 256),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
        end

        check("fifo_never_overflows", max_occ <= DEPTH, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog_timeout actual=%0d required=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
